// File: rtl/ud_speed_input_ctrl_pkg.sv
// Shared types and constants for the push-button input conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ud_speed_input_ctrl_pkg;

    // Debounce FSM state encoding
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // Output reset values: count up, fastest clock-select
    localparam logic       UD_RST = 1'b1;
    localparam logic [1:0] SW_RST = 2'b00;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int CNT_W_DEFAULT           = 20;

endpackage

// File: rtl/ud_speed_input_ctrl_debounce_fsm.sv
// Synchronizes and debounces one raw push-button; emits a strobe on accepted press.
// Latency: press_strobe 2 + DEBOUNCE_CYCLES cycles after a stable raw press (Mealy, comb from state).
// Backpressure: none; free-running, strobe is fire-and-forget.
// Ports: clk, reset (async, active-high), btn (raw, async), press_strobe (1-cycle),
//        stable_level (1 while the debounced button is considered held).
module debounce_fsm
    import ud_speed_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press_strobe,
    output logic stable_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    db_state_t        state_q;
    db_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter is cleared on every state change and in the two resting states,
    // so only the two wait states ever carry a non-zero count.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        press_strobe = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = HELD;
                    press_strobe = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync2) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (sync2) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stable_level = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/ud_speed_input_ctrl.sv
// Turns two bouncing buttons into a toggling UD level and a stepping 2-bit SW select.
// Latency: outputs and *_pulse change 1 cycle after the debouncer's press strobe (3 + DEBOUNCE_CYCLES from raw press).
// Backpressure: none; outputs are levels held stable >= DEBOUNCE_CYCLES between changes.
// Ports: clk, reset (async, active-high), btn_ud, btn_speed (raw, async),
//        UD (1 = up), SW[1:0] (clock select), ud_pulse, speed_pulse (1-cycle strobes).
module ud_speed_input_ctrl
    import ud_speed_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ud,
    input  logic       btn_speed,
    output logic       UD,
    output logic [1:0] SW,
    output logic       ud_pulse,
    output logic       speed_pulse
);

    logic ud_strobe;
    logic speed_strobe;
    logic ud_level_unused;
    logic speed_level_unused;

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_ud (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn_ud),
        .press_strobe (ud_strobe),
        .stable_level (ud_level_unused)
    );

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_speed (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn_speed),
        .press_strobe (speed_strobe),
        .stable_level (speed_level_unused)
    );

    // Channels are independent, so simultaneous strobes both take effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            UD          <= UD_RST;
            SW          <= SW_RST;
            ud_pulse    <= 1'b0;
            speed_pulse <= 1'b0;
        end else begin
            ud_pulse    <= ud_strobe;
            speed_pulse <= speed_strobe;
            if (ud_strobe)    UD <= ~UD;
            if (speed_strobe) SW <= SW + 2'd1;   // wraps 3 -> 0
        end
    end

endmodule
